// File: rtl/lsu_mem_ctrl.sv
// LSU memory-access engine: issues one load/store per instruction over a
// valid/ready request/response channel and presents write-back data to the WBU.
// Non-memory instructions pass straight through in IDLE with no added latency.
// Optional misaligned-access trap: define LSU_MISALIGN_CHECK_EN.
module lsu_mem_ctrl #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic              i_MemWr,
   input  logic [2:0]        i_MemOP,
   input  logic [1:0]        i_RegSrc,
   input  logic [ADDR_W-1:0] i_ALUres,
   input  logic [DATA_W-1:0] i_R_rs2,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_wen,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   output logic [7:0]        mem_req_wstrb,
   input  logic              mem_rsp_valid,
   output logic              mem_rsp_ready,
   input  logic [DATA_W-1:0] mem_rsp_rdata,
   output logic              lsu_to_wbu_valid,
   input  logic              wbu_allow_in,
   output logic [DATA_W-1:0] o_wbdata,
   output logic              o_misalign
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RSP  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [DATA_W-1:0] r_rdata;
   logic              w_is_mem;
   logic              w_is_load;
   logic              w_idle_pass;
   logic [2:0]        w_off;
   logic [DATA_W-1:0] w_shift;
   logic [DATA_W-1:0] w_load;
   logic [7:0]        w_strb;

   assign w_is_mem    = i_MemWr | (i_RegSrc == 2'b01);
   // A store wins if both store and load-writeback are flagged.
   assign w_is_load   = ~i_MemWr & (i_RegSrc == 2'b01);
   assign w_idle_pass = (r_state == IDLE) & lsu_valid & ~w_is_mem;
   assign w_off       = i_ALUres[2:0];
   assign w_shift     = r_rdata >> {w_off, 3'b000};

`ifdef LSU_MISALIGN_CHECK_EN
   logic w_misalign;
   logic r_misalign;

   // Misalignment of the held access, by access size.
   always_comb begin
      w_misalign = 1'b0;
      case (i_MemOP[1:0])
         2'b01:   w_misalign = w_off[0];
         2'b10:   w_misalign = |w_off[1:0];
         2'b11:   w_misalign = |w_off;
         default: w_misalign = 1'b0;
      endcase
   end

   // Flag set on trap entry from IDLE, cleared when DONE retires.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_misalign <= 1'b0;
      end else if ((r_state == IDLE) && lsu_valid && w_is_mem && w_misalign) begin
         r_misalign <= 1'b1;
      end else if ((r_state == DONE) && wbu_allow_in) begin
         r_misalign <= 1'b0;
      end
   end

   assign o_misalign = r_misalign;
`else
   assign o_misalign = 1'b0;
`endif

   // Next-state logic for the access sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (lsu_valid && w_is_mem) begin
`ifdef LSU_MISALIGN_CHECK_EN
               w_state_nxt = w_misalign ? DONE : REQ;
`else
               w_state_nxt = REQ;
`endif
            end
         end
         REQ:     if (mem_req_ready) w_state_nxt = RSP;
         RSP:     if (mem_rsp_valid) w_state_nxt = DONE;
         DONE:    if (wbu_allow_in) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register; reset abandons any outstanding transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Capture response data (store acks are captured too but never used).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata <= '0;
      end else if ((r_state == RSP) && mem_rsp_valid) begin
         r_rdata <= mem_rsp_rdata;
      end
   end

   // Load lane extraction and extension.
   always_comb begin
      w_load = '0;
      case (i_MemOP)
         3'b000:  w_load = {{(DATA_W-8){w_shift[7]}}, w_shift[7:0]};
         3'b001:  w_load = {{(DATA_W-16){w_shift[15]}}, w_shift[15:0]};
         3'b010:  w_load = {{(DATA_W-32){w_shift[31]}}, w_shift[31:0]};
         3'b011:  w_load = w_shift;
         3'b100:  w_load = {{(DATA_W-8){1'b0}}, w_shift[7:0]};
         3'b101:  w_load = {{(DATA_W-16){1'b0}}, w_shift[15:0]};
         3'b110:  w_load = {{(DATA_W-32){1'b0}}, w_shift[31:0]};
         default: w_load = '0;
      endcase
   end

   // Byte strobes; lanes shifted past bit 7 fall off the 8-bit result.
   always_comb begin
      w_strb = 8'h00;
      case (i_MemOP[1:0])
         2'b00:   w_strb = 8'h01 << w_off;
         2'b01:   w_strb = 8'h03 << w_off;
         2'b10:   w_strb = 8'h0F << w_off;
         default: w_strb = 8'hFF;
      endcase
   end

   // Request channel; fields are only driven while the request is offered.
   always_comb begin
      mem_req_valid = (r_state == REQ);
      mem_req_wen   = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      mem_req_wstrb = 8'h00;
      if (r_state == REQ) begin
         mem_req_wen   = i_MemWr;
         mem_req_addr  = {i_ALUres[ADDR_W-1:3], 3'b000};
         mem_req_wdata = i_R_rs2 << {w_off, 3'b000};
         mem_req_wstrb = i_MemWr ? w_strb : 8'h00;
      end
   end

   // Handshakes back to the pipeline and forward to the WBU.
   always_comb begin
      mem_rsp_ready    = (r_state == RSP);
      lsu_to_wbu_valid = w_idle_pass | (r_state == DONE);
      lsu_ready        = (w_idle_pass | (r_state == DONE)) & wbu_allow_in;
      if ((r_state == DONE) && o_misalign) begin
         o_wbdata = '0;
      end else if (w_is_load) begin
         o_wbdata = w_load;
      end else begin
         o_wbdata = i_ALUres;
      end
   end

endmodule
